// File: rtl/coax_pkg.sv
// coax_pkg: shared word width, word type and feeder states
// for the coax transmit path.
package coax_pkg;

    localparam int WORD_W = 10;

    typedef logic [WORD_W-1:0] coax_word_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DRAIN
    } tx_state_t;

endpackage

// File: rtl/coax_fifo.sv
// coax_fifo: single-clock word FIFO with occupancy count.
// Ports: clk, reset_n, wr_en/wr_data, rd_en/rd_data (head word,
// valid while !empty), full, empty, level (0..DEPTH).
module coax_fifo
    import coax_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  coax_word_t    wr_data,
    input  logic          rd_en,
    output coax_word_t    rd_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    localparam logic [LW-1:0] FULL_CNT = LW'(DEPTH);

    coax_word_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          push;
    logic          pop;

    // full is the registered count, so a same-cycle pop
    // never frees room for a write.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign level   = count;
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/coax_tx_feeder.sv
// coax_tx_feeder: buffers host words and feeds them to coax_tx
// as frames.
// Ports: host side wr_data/wr_strobe/commit, status full/level/
// busy/overflow; transmitter side tx_start/tx_data/tx_more out,
// tx_load_req/tx_active in.
module coax_tx_feeder
    import coax_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [WORD_W-1:0]      wr_data,
    input  logic                   wr_strobe,
    input  logic                   commit,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   overflow,
    output logic                   tx_start,
    output logic [WORD_W-1:0]      tx_data,
    output logic                   tx_more,
    input  logic                   tx_load_req,
    input  logic                   tx_active
);

    localparam int LW = $clog2(DEPTH) + 1;

    tx_state_t     state_q;
    tx_state_t     state_d;
    logic [LW-1:0] frame_len_q;
    logic [LW-1:0] frame_len_d;
    logic [LW-1:0] remaining_q;
    logic [LW-1:0] remaining_d;
    logic          seen_q;
    logic          seen_d;
    logic          more_d;
    logic          start_d;
    logic          load_word;
    logic          pop;
    logic          empty;
    coax_word_t    head;

    coax_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_strobe),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (commit && level != '0) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = SEND;
            end
            SEND: begin
                if (remaining_q == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (seen_q && !tx_active) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // seen_q records that coax_tx has gone active for this
    // frame; it may rise before the last word is handed over.
    always_comb begin
        pop         = 1'b0;
        load_word   = 1'b0;
        start_d     = 1'b0;
        more_d      = tx_more;
        remaining_d = remaining_q;
        frame_len_d = frame_len_q;
        seen_d      = seen_q | tx_active;
        unique case (state_q)
            IDLE: begin
                seen_d = 1'b0;
                if (commit && level != '0) begin
                    frame_len_d = level;
                end
            end
            LOAD: begin
                pop         = !empty;
                load_word   = 1'b1;
                start_d     = 1'b1;
                more_d      = (frame_len_q > LW'(1));
                remaining_d = frame_len_q - LW'(1);
            end
            SEND: begin
                if (remaining_q == '0) begin
                    more_d = 1'b0;
                end else if (tx_load_req) begin
                    pop         = !empty;
                    load_word   = 1'b1;
                    more_d      = (remaining_q > LW'(1));
                    remaining_d = remaining_q - LW'(1);
                end
            end
            DRAIN: begin
                more_d = 1'b0;
            end
            default: begin
                more_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_start    <= 1'b0;
            tx_more     <= 1'b0;
            tx_data     <= '0;
            overflow    <= 1'b0;
            frame_len_q <= '0;
            remaining_q <= '0;
            seen_q      <= 1'b0;
        end else begin
            tx_start    <= start_d;
            tx_more     <= more_d;
            overflow    <= wr_strobe && full;
            frame_len_q <= frame_len_d;
            remaining_q <= remaining_d;
            seen_q      <= seen_d;
            if (load_word) begin
                tx_data <= head;
            end
        end
    end

endmodule

// File: tb/tb_coax_tx_feeder.sv
// tb_coax_tx_feeder: directed stimulus with a word scoreboard
// checked by an independent monitor.
module tb_coax_tx_feeder;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] wr_data = '0;
    logic       wr_strobe = 1'b0;
    logic       commit = 1'b0;
    logic       tx_load_req = 1'b0;
    logic       tx_active = 1'b0;
    logic       full;
    logic [4:0] level;
    logic       busy;
    logic       overflow;
    logic       tx_start;
    logic [9:0] tx_data;
    logic       tx_more;

    int          checks = 0;
    int          errors = 0;
    logic [10:0] sb_q[$];
    bit          req_word = 1'b0;
    bit          mon_req;
    logic [10:0] mon_exp;

    coax_tx_feeder #(
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_data     (wr_data),
        .wr_strobe   (wr_strobe),
        .commit      (commit),
        .full        (full),
        .level       (level),
        .busy        (busy),
        .overflow    (overflow),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_more     (tx_more),
        .tx_load_req (tx_load_req),
        .tx_active   (tx_active)
    );

    always #5 clk = ~clk;

    // A word is presented with tx_start, or one edge after a
    // tx_load_req that the stimulus expects to be honoured.
    always @(posedge clk) begin
        mon_req = req_word;
        #1;
        if (tx_start || mon_req) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got %h more=%b want none",
                         tx_data, tx_more);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({tx_data, tx_more} !== mon_exp) begin
                    errors++;
                    $display("FAIL sb_word: got %h more=%b want %h more=%b",
                             tx_data, tx_more, mon_exp[10:1], mon_exp[0]);
                end
            end
        end
    end

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic expect_word(logic [9:0] v, logic m);
        sb_q.push_back({v, m});
    endtask

    task automatic wr(logic [9:0] v);
        wr_data   = v;
        wr_strobe = 1'b1;
        @(negedge clk);
        wr_strobe = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    task automatic load_req(bit honoured);
        tx_load_req = 1'b1;
        req_word    = honoured;
        @(negedge clk);
        tx_load_req = 1'b0;
        req_word    = 1'b0;
    endtask

    task automatic finish_frame(string name);
        @(negedge clk);
        tx_active = 1'b1;
        @(negedge clk);
        check({name, "_drain_more"}, tx_more, 0);
        check({name, "_drain_busy"}, busy, 1);
        tx_active = 1'b0;
        @(negedge clk);
        check({name, "_idle"}, busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_txdata", tx_data, 0);
        check("rst_full", full, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Three-word frame
        wr(10'h101);
        wr(10'h202);
        wr(10'h303);
        check("t1_level", level, 3);
        expect_word(10'h101, 1'b1);
        do_commit();
        check("t1_busy_load", busy, 1);
        check("t1_start_early", tx_start, 0);
        @(negedge clk);
        check("t1_start_2nd", tx_start, 1);
        expect_word(10'h202, 1'b1);
        load_req(1'b1);
        check("t1_start_pulse", tx_start, 0);
        expect_word(10'h303, 1'b0);
        load_req(1'b1);
        check("t1_level_empty", level, 0);
        load_req(1'b0);
        check("t1_hold_data", tx_data, 10'h303);
        finish_frame("t1");

        // Overflow at DEPTH
        for (int i = 0; i < 16; i++) begin
            wr(10'(16 + i));
            if (i == 14) check("t2_not_full", full, 0);
        end
        check("t2_full", full, 1);
        check("t2_level16", level, 16);
        wr(10'h3AA);
        check("t2_ovf", overflow, 1);
        @(negedge clk);
        check("t2_ovf_once", overflow, 0);
        check("t2_level_kept", level, 16);
        expect_word(10'(16), 1'b1);
        do_commit();
        @(negedge clk);
        for (int i = 1; i < 16; i++) begin
            expect_word(10'(16 + i), i < 15);
            load_req(1'b1);
        end
        check("t2_level_done", level, 0);
        finish_frame("t2");

        // Commit with nothing buffered
        do_commit();
        check("t3_busy_a", busy, 0);
        repeat (3) @(negedge clk);
        check("t3_busy_b", busy, 0);

        // Commit during a frame is ignored
        wr(10'h0A1);
        wr(10'h0A2);
        expect_word(10'h0A1, 1'b1);
        do_commit();
        @(negedge clk);
        wr(10'h3FF);
        do_commit();
        expect_word(10'h0A2, 1'b0);
        load_req(1'b1);
        finish_frame("t4a");
        check("t4_level1", level, 1);
        expect_word(10'h3FF, 1'b0);
        do_commit();
        @(negedge clk);
        finish_frame("t4b");
        check("t4_level0", level, 0);

        // Reset mid-frame
        for (int i = 0; i < 6; i++) wr(10'(8'h50 + i));
        expect_word(10'h050, 1'b1);
        do_commit();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t5_start", tx_start, 0);
        check("t5_more", tx_more, 0);
        check("t5_data", tx_data, 0);
        check("t5_busy", busy, 0);
        check("t5_level", level, 0);
        check("t5_full", full, 0);
        check("t5_ovf", overflow, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_commit();
        repeat (3) @(negedge clk);
        check("t5_no_frame", busy, 0);
        check("t5_level_after", level, 0);

        check("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/coax_tx_feeder.md
COAX_TX_FEEDER -- requirements
Module: coax_tx_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO word capacity; power of two, 2..64.
REQ-002 SHALL have port clk  input  1  single clock for all logic (the coax transmitter clock domain).
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port wr_data  input  10  coax data word from host.
REQ-005 SHALL have port wr_strobe  input  1  one-cycle write request for wr_data.
REQ-006 SHALL have port commit  input  1  one-cycle request to transmit all currently buffered words as one frame.
REQ-007 SHALL have port full  output  1  FIFO holds DEPTH words.
REQ-008 SHALL have port level  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-009 SHALL have port busy  output  1  frame in progress (state != IDLE).
REQ-010 SHALL have port overflow  output  1  one-cycle pulse when a write was dropped.
REQ-011 SHALL have port tx_start  output  1  one-cycle pulse telling coax_tx to begin a frame.
REQ-012 SHALL have port tx_data  output  10  word presented to coax_tx.
REQ-013 SHALL have port tx_more  output  1  another word of this frame follows tx_data.
REQ-014 SHALL have port tx_load_req  input  1  one-cycle pulse from coax_tx: tx_data latched, next word wanted.
REQ-015 SHALL have port tx_active  input  1  coax_tx is driving the line.

Function
REQ-016 SHALL accept wr_data when wr_strobe=1 and full=0 (full sampled before any same-cycle pop).
REQ-017 SHALL drop a write when full=1 and pulse overflow the following cycle; FIFO contents unchanged.
REQ-018 SHALL support simultaneous accepted write and pop; level unchanged that cycle.
REQ-019 SHALL implement states IDLE, LOAD, SEND, DRAIN.
REQ-020 IDLE: commit with level>0 SHALL latch frame_len=level (1..DEPTH) and go to LOAD; commit with level=0 SHALL be ignored.
REQ-021 commit outside IDLE SHALL be ignored; words written during a frame belong to the next frame.
REQ-022 LOAD: SHALL pop head word into tx_data, set tx_more=(frame_len>1), remaining=frame_len-1, pulse tx_start, go to SEND; tx_start is high exactly the second cycle after commit is sampled.
REQ-023 SEND: on tx_load_req with remaining>0, SHALL pop next word into tx_data, decrement remaining, set tx_more=(remaining>1 before decrement) on the next cycle.
REQ-024 SEND: when remaining=0, SHALL go to DRAIN; tx_load_req with remaining=0 SHALL be ignored.
REQ-025 DRAIN: SHALL wait until tx_active has been seen high and then low, then go to IDLE; tx_more=0 throughout.
REQ-026 tx_data SHALL hold its value between updates; only REQ-022/023 change it.
REQ-027 busy SHALL be combinationally (state != IDLE).

Reset
REQ-028 reset_n=0 SHALL asynchronously force state=IDLE, FIFO empty (level=0, full=0), tx_start=0, tx_more=0, tx_data=0, overflow=0, busy=0, frame_len=0, remaining=0.
REQ-029 reset mid-frame SHALL discard all buffered and in-flight words; no tx_start until a new commit.

Structure
REQ-030 SHALL place the 10-bit word width constant and the state enumeration in shared package coax_pkg.
REQ-031 SHALL implement buffering in one sub-module coax_fifo (synchronous, one clock, same async active-low reset, write/pop/full/empty/level).

Verification
REQ-032 Write 3 words 0x101,0x202,0x303, commit -> tx_start 2 cycles later with tx_data=0x101,tx_more=1; tx_load_req pulses yield 0x202 (more=1), 0x303 (more=0); DRAIN, then IDLE after tx_active falls.
REQ-033 Write 17 words with DEPTH=16 -> full=1 after 16th, overflow pulse once, level=16.
REQ-034 commit with level=0 -> no tx_start, busy stays 0.
REQ-035 During a 2-word frame, write 0x3FF and commit again -> second commit ignored; 0x3FF remains, level=1 after frame; later commit sends it alone with tx_more=0.
REQ-036 Assert reset_n=0 in SEND with 5 words remaining -> all outputs 0 immediately, level=0; later commit with level=0 produces nothing.
